// File: rtl/cache_line_fill_if.sv
// AXI4 read-channel bundle (AR + R) between the line-fill engine and the backend.
// Ports (modport master = fill engine, slave = backend/interconnect):
//   AR: m_arvalid, m_arready, m_araddr, m_arid, m_arlen, m_arsize, m_arburst
//   R : m_rvalid, m_rready, m_rdata, m_rid, m_rresp, m_rlast
interface cache_line_fill_if #(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ID_WIDTH   = 1
);
    logic                  m_arvalid;
    logic                  m_arready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [ID_WIDTH-1:0]   m_arid;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;

    logic                  m_rvalid;
    logic                  m_rready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [ID_WIDTH-1:0]   m_rid;
    logic [1:0]            m_rresp;
    logic                  m_rlast;

    modport master (
        output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
        output m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast
    );
endinterface

// File: rtl/cache_line_fill.sv
// Cache line-fill engine: accepts one line-fill request, issues a single INCR
// burst read on the backend AXI4 port, streams each returned beat to the cache
// data RAM write port and reports completion with an error flag.
// Ports:
//   axis_aclk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr  fill request (low line-offset bits ignored)
//   fill_valid/fill_ready/fill_data/fill_beat/fill_last  data RAM write stream
//   done_valid/done_error/done_addr  one-cycle completion report
//   m_axi                       AXI4 AR/R channels (master modport)
module cache_line_fill #(
    parameter int unsigned ADDR_WIDTH         = 48,
    parameter int unsigned LINE_BYTES         = 512,
    parameter int unsigned BACKEND_DATA_WIDTH = 512,
    parameter int unsigned BACKEND_ID_WIDTH   = 1,
    parameter int unsigned FILL_ID            = 0,
    localparam int unsigned BEATS  = LINE_BYTES * 8 / BACKEND_DATA_WIDTH,
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                          axis_aclk,
    input  logic                          rst,

    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,

    output logic                          fill_valid,
    input  logic                          fill_ready,
    output logic [BACKEND_DATA_WIDTH-1:0] fill_data,
    output logic [BEAT_W-1:0]             fill_beat,
    output logic                          fill_last,

    output logic                          done_valid,
    output logic                          done_error,
    output logic [ADDR_WIDTH-1:0]         done_addr,

    cache_line_fill_if.master             m_axi
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned SIZE_V = $clog2(BACKEND_DATA_WIDTH / 8);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN,
        DONE
    } state_t;

    state_t                  state, next_state;
    logic [BEAT_W-1:0]       cnt_q, cnt_next;
    logic                    err_q, err_next;
    logic                    arvalid_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    rready_c;
    logic                    r_bad_c;

    // Fixed burst shape: one full line, INCR, full-width beats.
    assign m_axi.m_arvalid = arvalid_q;
    assign m_axi.m_araddr  = araddr_q;
    assign m_axi.m_arid    = BACKEND_ID_WIDTH'(FILL_ID);
    assign m_axi.m_arlen   = 8'(BEATS - 1);
    assign m_axi.m_arsize  = 3'(SIZE_V);
    assign m_axi.m_arburst = 2'b01;
    assign m_axi.m_rready  = rready_c;

    // Per-beat error: non-OKAY response or a beat that is not ours.
    assign r_bad_c = (m_axi.m_rresp != 2'b00) ||
                     (m_axi.m_rid != BACKEND_ID_WIDTH'(FILL_ID));

    // State register.
    always_ff @(posedge axis_aclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, beat bookkeeping and combinational stream outputs.
    always_comb begin
        next_state = state;
        cnt_next   = cnt_q;
        err_next   = err_q;
        req_ready  = 1'b0;
        fill_valid = 1'b0;
        rready_c   = 1'b0;
        fill_data  = '0;
        fill_beat  = '0;
        fill_last  = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    next_state = ADDR;
                end
            end

            ADDR: begin
                if (m_axi.m_arready) begin
                    next_state = DATA;
                end
            end

            DATA: begin
                fill_valid = m_axi.m_rvalid;
                rready_c   = fill_ready;
                fill_data  = m_axi.m_rdata;
                fill_beat  = cnt_q;
                fill_last  = (cnt_q == LAST_BEAT);
                if (m_axi.m_rvalid && fill_ready) begin
                    if (r_bad_c) begin
                        err_next = 1'b1;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        // Line complete; a missing RLAST means the slave has more to send.
                        if (m_axi.m_rlast) begin
                            next_state = DONE;
                        end else begin
                            err_next   = 1'b1;
                            next_state = DRAIN;
                        end
                    end else if (m_axi.m_rlast) begin
                        // Short burst: the rest of the line is never written.
                        err_next   = 1'b1;
                        next_state = DONE;
                    end else begin
                        cnt_next = cnt_q + BEAT_W'(1);
                    end
                end
            end

            DRAIN: begin
                // Swallow surplus beats until the slave closes the burst.
                rready_c = 1'b1;
                if (m_axi.m_rvalid && m_axi.m_rlast) begin
                    next_state = DONE;
                end
            end

            DONE: begin
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered AR channel, beat counter, error flag and completion report.
    always_ff @(posedge axis_aclk or posedge rst) begin
        if (rst) begin
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            done_valid <= 1'b0;
            done_error <= 1'b0;
            done_addr  <= '0;
        end else begin
            cnt_q      <= cnt_next;
            err_q      <= err_next;
            done_valid <= (next_state == DONE);

            if (state == IDLE && req_valid) begin
                arvalid_q <= 1'b1;
                araddr_q  <= req_addr & LINE_MASK;
            end else if (state == ADDR && m_axi.m_arready) begin
                arvalid_q <= 1'b0;
            end

            if (next_state == DONE) begin
                done_error <= err_next;
                done_addr  <= araddr_q;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Randomised and directed checks of cache_line_fill against a burst-level model.
module tb_cache_line_fill;

    localparam int unsigned AW    = 48;
    localparam int unsigned DW    = 512;
    localparam int unsigned IW    = 1;
    localparam int unsigned BEATS = 8;
    localparam int unsigned BW    = 3;
    localparam logic [AW-1:0] MASK = ~48'h1FF;

    logic          axis_aclk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          fill_valid;
    logic          fill_ready;
    logic [DW-1:0] fill_data;
    logic [BW-1:0] fill_beat;
    logic          fill_last;
    logic          done_valid;
    logic          done_error;
    logic [AW-1:0] done_addr;

    cache_line_fill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    cache_line_fill #(
        .ADDR_WIDTH(AW), .LINE_BYTES(512), .BACKEND_DATA_WIDTH(DW),
        .BACKEND_ID_WIDTH(IW), .FILL_ID(0)
    ) dut (
        .axis_aclk (axis_aclk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .fill_valid(fill_valid),
        .fill_ready(fill_ready),
        .fill_data (fill_data),
        .fill_beat (fill_beat),
        .fill_last (fill_last),
        .done_valid(done_valid),
        .done_error(done_error),
        .done_addr (done_addr),
        .m_axi     (bus.master)
    );

    always #5 axis_aclk = ~axis_aclk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge axis_aclk) cyc <= cyc + 1;

    // Burst description shared by driver and model (one burst outstanding).
    logic [DW-1:0] beat_data [0:15];
    logic [1:0]    beat_resp [0:15];
    logic          beat_id   [0:15];
    int            exp_n;
    int            exp_written;
    bit            exp_err;
    logic [AW-1:0] exp_req;

    // Model/observer state owned by the compare process.
    bit            chk_en = 1'b0;
    bit            busy = 1'b0;
    bit            ar_pend = 1'b0;
    int            rcount = 0;
    int            last_r_cyc = -10;
    int            acc_cyc = 0;
    int            lat = 0;
    int            n_fill = 0;
    int            n_last = 0;
    bit            last_done_err = 1'b0;
    logic [AW-1:0] last_araddr = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Beats written to the line: up to the first RLAST (at n-1) or the line end.
    function automatic int model_written(input int n);
        return (n < int'(BEATS)) ? n : int'(BEATS);
    endfunction

    function automatic bit model_err(input int n);
        bit e = (n != int'(BEATS));
        for (int i = 0; i < model_written(n); i++)
            if (beat_resp[i] != 2'b00 || beat_id[i] != 1'b0) e = 1'b1;
        return e;
    endfunction

    // Cycle-by-cycle comparison against the burst model.
    initial begin
        forever begin
            @(negedge axis_aclk);
            if (chk_en) begin
                bit exp_done;
                exp_done = busy && !ar_pend && rcount == exp_n && last_r_cyc == cyc - 1;
                chk("req_ready", 512'(req_ready), 512'(!busy));
                chk("m_arvalid", 512'(bus.m_arvalid), 512'(ar_pend));
                if (bus.m_arvalid) begin
                    last_araddr = bus.m_araddr;
                    chk("m_araddr", 512'(bus.m_araddr), 512'(exp_req & MASK));
                    chk("m_arlen", 512'(bus.m_arlen), 512'(BEATS - 1));
                    chk("m_arsize", 512'(bus.m_arsize), 512'(6));
                    chk("m_arburst", 512'(bus.m_arburst), 512'(1));
                    chk("m_arid", 512'(bus.m_arid), 512'(0));
                    if (bus.m_arready) ar_pend = 1'b0;
                end
                if (bus.m_rvalid) begin
                    if (rcount < exp_written) begin
                        chk("fill_valid", 512'(fill_valid), 512'(1));
                        chk("m_rready_mirror", 512'(bus.m_rready), 512'(fill_ready));
                        chk("fill_data", fill_data, beat_data[rcount]);
                        chk("fill_beat", 512'(fill_beat), 512'(rcount));
                        chk("fill_last", 512'(fill_last), 512'(rcount == int'(BEATS) - 1));
                        if (fill_valid && fill_ready) begin
                            n_fill++;
                            if (fill_last) n_last++;
                        end
                    end else begin
                        chk("drain_fill_valid", 512'(fill_valid), 512'(0));
                        chk("drain_m_rready", 512'(bus.m_rready), 512'(1));
                    end
                    if (bus.m_rready) begin
                        rcount++;
                        last_r_cyc = cyc;
                    end
                end else begin
                    chk("fill_valid_idle", 512'(fill_valid), 512'(0));
                end
                chk("done_valid", 512'(done_valid), 512'(exp_done));
                if (done_valid) begin
                    chk("done_error", 512'(done_error), 512'(exp_err));
                    chk("done_addr", 512'(done_addr), 512'(exp_req & MASK));
                    last_done_err = done_error;
                    lat = cyc - acc_cyc;
                    busy = 1'b0;
                end
                if (req_valid && req_ready) begin
                    busy = 1'b1;
                    ar_pend = 1'b1;
                    rcount = 0;
                    n_fill = 0;
                    n_last = 0;
                    acc_cyc = cyc;
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_m_arvalid"}, 512'(bus.m_arvalid), 512'(0));
        chk({tag, "_m_araddr"}, 512'(bus.m_araddr), 512'(0));
        chk({tag, "_done_valid"}, 512'(done_valid), 512'(0));
        chk({tag, "_done_error"}, 512'(done_error), 512'(0));
        chk({tag, "_done_addr"}, 512'(done_addr), 512'(0));
        chk({tag, "_fill_valid"}, 512'(fill_valid), 512'(0));
        chk({tag, "_m_rready"}, 512'(bus.m_rready), 512'(0));
        chk({tag, "_req_ready"}, 512'(req_ready), 512'(1));
    endtask

    // fr_mode: 0 random, 1 toggle starting at 1, 2 always ready.
    task automatic run_txn(input logic [AW-1:0] addr, input int n, input int bad_beat,
                           input int bad_kind, input int ar_pct, input int rv_pct,
                           input int fr_mode, input int ar_hold, input int rst_after,
                           input bit rnd_resp);
        bit accepted = 0, ar_done = 0, seen_done = 0;
        bit acc, arh, rh, dn;
        int idx = 0, hold = ar_hold, cycles = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 16; k++) beat_data[i][k*32 +: 32] = $urandom;
            beat_resp[i] = 2'b00;
            beat_id[i]   = 1'b0;
            if (rnd_resp && ($urandom % 12) == 0) beat_resp[i] = 2'($urandom_range(1, 3));
            if (rnd_resp && ($urandom % 20) == 0) beat_id[i] = 1'b1;
            if (i == bad_beat && bad_kind == 1) beat_resp[i] = 2'b10;
            if (i == bad_beat && bad_kind == 2) beat_id[i] = 1'b1;
        end
        exp_n       = n;
        exp_req     = addr;
        exp_written = model_written(n);
        exp_err     = model_err(n);
        req_addr    = addr;
        req_valid   = 1'b1;
        fill_ready  = (fr_mode == 0) ? 1'($urandom % 2) : 1'b1;
        while (!seen_done && cycles < 3000) begin
            @(negedge axis_aclk);
            acc = req_valid && req_ready;
            arh = bus.m_arvalid && bus.m_arready;
            rh  = bus.m_rvalid && bus.m_rready;
            dn  = done_valid;
            @(posedge axis_aclk);
            #1;
            cycles++;
            if (acc) begin
                req_valid = 1'b0;
                accepted  = 1'b1;
            end
            if (arh) ar_done = 1'b1;
            if (accepted && !ar_done) begin
                if (hold > 0) begin
                    hold--;
                    bus.m_arready = 1'b0;
                end else begin
                    bus.m_arready = 1'(($urandom % 100) < ar_pct);
                end
            end else begin
                bus.m_arready = 1'b0;
            end
            if (rh) idx++;
            if (rst_after >= 0 && idx == rst_after) begin
                chk_en = 1'b0;
                rst = 1'b1;
                bus.m_rvalid = 1'b0;
                bus.m_arready = 1'b0;
                req_valid = 1'b0;
                #2;
                check_reset_vals("midburst_reset");
                @(negedge axis_aclk);
                rst = 1'b0;
                busy = 1'b0;
                ar_pend = 1'b0;
                rcount = 0;
                @(posedge axis_aclk);
                #1;
                chk_en = 1'b1;
                return;
            end
            if (!bus.m_rvalid || rh) begin
                if (ar_done && idx < n && ($urandom % 100) < rv_pct) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = beat_data[idx];
                    bus.m_rresp  = beat_resp[idx];
                    bus.m_rid    = beat_id[idx];
                    bus.m_rlast  = (idx == n - 1);
                end else begin
                    bus.m_rvalid = 1'b0;
                end
            end
            case (fr_mode)
                0: fill_ready = 1'(($urandom % 100) < 60);
                1: fill_ready = ~fill_ready;
                default: fill_ready = 1'b1;
            endcase
            if (dn) seen_done = 1'b1;
        end
        if (!seen_done) chk("txn_timeout", 512'(0), 512'(1));
        chk("beats_consumed", 512'(idx), 512'(n));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        fill_ready = 1'b0;
        bus.m_arready = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata = '0;
        bus.m_rid = '0;
        bus.m_rresp = 2'b00;
        bus.m_rlast = 1'b0;
        repeat (3) @(posedge axis_aclk);
        #1;
        check_reset_vals("por");
        @(negedge axis_aclk);
        rst = 1'b0;
        @(posedge axis_aclk);
        #1;
        chk_en = 1'b1;

        // Ready slave, full OKAY burst, no stalls.
        run_txn(48'h0000_1234_5678, 8, -1, 0, 100, 100, 2, 0, -1, 0);
        chk("t1_araddr", 512'(last_araddr), 512'(48'h0000_1234_5600));
        chk("t1_latency", 512'(lat), 512'(2 + BEATS));
        chk("t1_fills", 512'(n_fill), 512'(8));
        chk("t1_last_count", 512'(n_last), 512'(1));
        chk("t1_err", 512'(last_done_err), 512'(0));

        // fill_ready toggling.
        run_txn(48'h0000_1234_5678, 8, -1, 0, 100, 100, 1, 0, -1, 0);
        chk("t2_fills", 512'(n_fill), 512'(8));
        chk("t2_err", 512'(last_done_err), 512'(0));

        // SLVERR on beat 3.
        run_txn(48'h0000_0ABC_DE00, 8, 3, 1, 100, 100, 2, 0, -1, 0);
        chk("t3_fills", 512'(n_fill), 512'(8));
        chk("t3_err", 512'(last_done_err), 512'(1));

        // RLAST on beat 5.
        run_txn(48'h7FFF_FFFF_FFFF, 6, -1, 0, 100, 100, 2, 0, -1, 0);
        chk("t4_fills", 512'(n_fill), 512'(6));
        chk("t4_err", 512'(last_done_err), 512'(1));
        chk("t4_latency", 512'(lat), 512'(2 + 6));

        // Ten beats, two drained.
        run_txn(48'h0000_0000_0200, 10, -1, 0, 100, 100, 2, 0, -1, 0);
        chk("t5_fills", 512'(n_fill), 512'(8));
        chk("t5_err", 512'(last_done_err), 512'(1));

        // Reset after beat 2, then a request with AR held off.
        run_txn(48'h0000_5555_5555, 8, -1, 0, 100, 100, 2, 0, 3, 0);
        run_txn(48'h0000_0F0F_0F40, 8, -1, 0, 100, 100, 0, 6, -1, 0);
        chk("t7_fills", 512'(n_fill), 512'(8));
        chk("t7_err", 512'(last_done_err), 512'(0));

        // Randomised bursts.
        for (int t = 0; t < 40; t++) begin
            int n;
            logic [AW-1:0] a;
            a = {16'($urandom), 32'($urandom)};
            case ($urandom % 4)
                0: n = int'($urandom_range(1, 7));
                1: n = int'($urandom_range(9, 11));
                default: n = 8;
            endcase
            run_txn(a, n, int'($urandom % 10), int'($urandom % 3),
                    int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                    int'($urandom % 3), int'($urandom % 3), -1, 1);
            repeat (int'($urandom % 3)) @(posedge axis_aclk);
            #1;
        end

        repeat (3) @(posedge axis_aclk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
